stream_sum_pn: RTL

STREAM_SUM_PN -- requirements
Module: stream_sum_pn

---
 rtl/stream_sum_pn.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/stream_sum_pn.sv
`default_nettype none
// ============================================================================
//  Module   : stream_sum_pn
//  Brief    : Block accumulator. A length strobe opens a block of N signed
//             samples; their (wrapping or saturating) sum is queued in a
//             result FIFO. CTRL/STATUS are reached via a simple cfg port.
//  Options  : define STREAM_SUM_OVF_COUNTER_EN to add the 16-bit saturating
//             overflow counter at 0x08 (reads 0 when undefined).
//  Revision : 1.0 - initial release
// ============================================================================
module stream_sum_pn #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] din_value,
  input  logic              din_en,
  output logic              din_rdy,
  input  logic              dout_en,
  output logic [DATA_W-1:0] dout_value,
  output logic              dout_rdy,
  input  logic [7:0]        len_value,
  input  logic              len_en,
  output logic              len_rdy,
  input  logic [7:0]        cfg_address,
  input  logic [31:0]       cfg_data_in,
  input  logic              cfg_op,
  input  logic              cfg_en,
  output logic [31:0]       cfg_data_out,
  output logic              cfg_rdy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_OVFCNT = 8'h08;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    PUSH  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_sum;
  logic [7:0]          r_count;
  logic                r_pause;
  logic                r_sat;
  logic                r_ovf;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;

  logic                w_len_fire;
  logic                w_din_fire;
  logic                w_pop;
  logic                w_push;
  logic [DATA_W-1:0]   w_push_data;
  logic                w_full;
  logic [DATA_W-1:0]   w_add;
  logic                w_add_ovf;
  logic [DATA_W-1:0]   w_sum_next;
  logic                w_cfg_wr;
  logic [7:0]          w_level8;
  logic [31:0]         w_rdata;
  logic                w_unused_cfg;

  // Handshake readiness; pause gates only the sample input.
  assign len_rdy    = (r_state == IDLE);
  assign din_rdy    = (r_state == ACCUM) && !r_pause;
  assign dout_rdy   = (r_level != '0);
  assign dout_value = dout_rdy ? r_mem[r_rd_ptr] : '0;
  assign cfg_rdy    = 1'b1;

  assign w_len_fire = len_en && len_rdy && (len_value != 8'd0);
  assign w_din_fire = din_en && din_rdy;
  assign w_pop      = dout_en && dout_rdy;
  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_cfg_wr   = cfg_en && cfg_op;
  assign w_level8   = 8'(r_level);

  // Signed overflow: equal operand signs, result sign differs.
  assign w_add      = r_sum + din_value;
  assign w_add_ovf  = (r_sum[DATA_W-1] == din_value[DATA_W-1]) &&
                      (w_add[DATA_W-1] != r_sum[DATA_W-1]);

  // Select wrapped or clamped sum; the clamp direction follows operand sign.
  always_comb begin
    w_sum_next = w_add;
    if (w_add_ovf && r_sat) begin
      w_sum_next = r_sum[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state and FIFO push request. The final sample is pushed straight
  // into the FIFO when there is room, so the result is visible the very next
  // cycle; PUSH is only occupied while waiting for FIFO space.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_push_data  = r_sum;
    case (r_state)
      IDLE: begin
        if (w_len_fire) w_state_next = ACCUM;
      end
      ACCUM: begin
        if (w_din_fire && (r_count == 8'd1)) begin
          if (!w_full) begin
            w_push       = 1'b1;
            w_push_data  = w_sum_next;
            w_state_next = IDLE;
          end else begin
            w_state_next = PUSH;
          end
        end
      end
      PUSH: begin
        // Fullness is judged at the start of the cycle: a same-cycle pop
        // does not let the push through until the following cycle.
        if (!w_full) begin
          w_push       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Accumulator and remaining-sample counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sum   <= '0;
      r_count <= 8'd0;
    end else if (w_len_fire) begin
      r_sum   <= '0;
      r_count <= len_value;
    end else if (w_din_fire) begin
      r_sum   <= w_sum_next;
      r_count <= r_count - 8'd1;
    end
  end

  // FIFO storage; contents are invalidated by the pointer/level reset.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  // FIFO pointers and fill level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      r_level <= r_level + {{(LW-1){1'b0}}, w_push} - {{(LW-1){1'b0}}, w_pop};
    end
  end

  // CTRL register and sticky overflow flag (a new overflow beats a clear).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pause <= 1'b0;
      r_sat   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_cfg_wr && (cfg_address == ADDR_CTRL)) begin
        r_pause <= cfg_data_in[0];
        r_sat   <= cfg_data_in[1];
      end
      if (w_din_fire && w_add_ovf)
        r_ovf <= 1'b1;
      else if (w_cfg_wr && (cfg_address == ADDR_STATUS) && cfg_data_in[24])
        r_ovf <= 1'b0;
    end
  end

`ifdef STREAM_SUM_OVF_COUNTER_EN
  logic [15:0] r_ovf_cnt;

  // Saturating overflow event counter; any write clears it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_ovf_cnt <= 16'd0;
    else if (w_cfg_wr && (cfg_address == ADDR_OVFCNT))
      r_ovf_cnt <= 16'd0;
    else if (w_din_fire && w_add_ovf && (r_ovf_cnt != 16'hFFFF))
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end
`endif

  // Combinational register read; zero when no read is in progress.
  always_comb begin
    w_rdata = 32'd0;
    if (cfg_en && !cfg_op) begin
      case (cfg_address)
        ADDR_CTRL:   w_rdata = {30'd0, r_sat, r_pause};
        ADDR_STATUS: w_rdata = {7'd0, r_ovf, w_level8, r_count, 6'd0, r_state};
`ifdef STREAM_SUM_OVF_COUNTER_EN
        ADDR_OVFCNT: w_rdata = {16'd0, r_ovf_cnt};
`endif
        default:     w_rdata = 32'd0;
      endcase
    end
  end

  assign cfg_data_out = w_rdata;

  // Write-data bits with no register behind them.
  assign w_unused_cfg = ^{cfg_data_in[31:25], cfg_data_in[23:2]};

endmodule
`default_nettype wire
